// File: rtl/disp_pkg.sv
// Shared types and constants for the winner-take-all disparity selector.
// The cost width and the "no second candidate yet" sentinel live here.
package disp_pkg;

  localparam int COST_W = 8;
  localparam logic [COST_W-1:0] COST_SENTINEL = 8'hFF;

  typedef struct packed {
    logic [7:0]  disp;
    logic [7:0]  cost;
    logic [15:0] coords;
    logic        conf;
  } disp_result_t;

  typedef enum logic {IDLE, ACCUM} sel_state_t;

endpackage

// File: rtl/disparity_select_result_fifo.sv
// Result queue with a registered head. The head register counts as one of
// the FIFO_DEPTH slots, and a freshly written entry never falls through.
module result_fifo
  import disp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  disp_result_t push_data,
  input  logic         ready,
  output disp_result_t head,
  output logic         head_valid,
  output logic         full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  disp_result_t mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, avail;
  logic          pop, wr_en, empty;

  assign pop   = head_valid && ready;
  assign full  = (cnt == DEPTH_C);
  assign empty = (cnt == '0);
  assign wr_en = push && (!full || pop);
  // Entries already stored that remain after this cycle's pop; a push
  // landing this cycle is only visible on the following edge.
  assign avail = empty ? '0 : cnt - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      cnt        <= cnt + (AW+1)'(wr_en) - (AW+1)'(pop);
      head_valid <= (avail != '0);
      if (avail != '0) head <= mem[rd_ptr + AW'(pop)];
    end
  end

endmodule

// File: rtl/disparity_select.sv
// Winner-take-all over the per-candidate cost stream: lowest cost wins,
// ceiling and uniqueness decide conf, results queue toward the map writer.
module disparity_select
  import disp_pkg::*;
#(
  parameter int NUM_DISP    = 64,
  parameter int MAX_COST    = 200,
  parameter int UNIQ_MARGIN = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sum,
  input  logic [15:0] in_coords,
  input  logic [15:0] blk_index_i,
  input  logic        sum_valid,
  input  logic        clear_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_disp,
  output logic [7:0]  out_cost,
  output logic [15:0] out_coords,
  output logic        out_conf,
  output logic        seq_err,
  output logic        overflow
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_DISP - 1);
  localparam bit          SINGLE   = (NUM_DISP == 1);

  function automatic logic calc_conf(input logic [7:0] b, input logic [7:0] s);
    logic [8:0] gap;
    gap = {1'b0, s} - {1'b0, b};
    return (int'(b) <= MAX_COST) && (int'(gap) >= UNIQ_MARGIN);
  endfunction

  function automatic disp_result_t make_result(input logic [7:0] b, input logic [7:0] s,
                                               input logic [7:0] idx, input logic [15:0] c);
    disp_result_t r;
    r.disp   = idx;
    r.cost   = b;
    r.coords = c;
    r.conf   = calc_conf(b, s);
    return r;
  endfunction

  sel_state_t   state;
  logic [15:0]  exp_idx, coords_lat;
  logic [7:0]   best, second, best_idx;
  logic [7:0]   acc_best, acc_second, acc_idx;
  logic         in_seq, idx_zero, idle_start, acc_ok, acc_restart, start, complete, seq_evt;
  disp_result_t res_p0;
  logic         vld_p0;
  disp_result_t head;
  logic         fifo_full, drop;

  always_comb begin
    acc_best   = best;
    acc_second = second;
    acc_idx    = best_idx;
    if (sum < best) begin
      acc_second = best;
      acc_best   = sum;
      acc_idx    = blk_index_i[7:0];
    end else if (sum < second) begin
      acc_second = sum;
    end
  end

  assign idx_zero    = (blk_index_i == '0);
  assign in_seq      = (blk_index_i == exp_idx) && (in_coords == coords_lat);
  assign idle_start  = sum_valid && (state == IDLE) && idx_zero;
  assign acc_ok      = sum_valid && (state == ACCUM) && in_seq;
  assign acc_restart = sum_valid && (state == ACCUM) && !in_seq && idx_zero;
  assign start       = idle_start || acc_restart;
  assign complete    = (idle_start && SINGLE) || (acc_ok && (blk_index_i == LAST_IDX));
  assign seq_evt     = sum_valid && (((state == IDLE) && !idx_zero) ||
                                     ((state == ACCUM) && !in_seq));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      exp_idx <= '0;
      vld_p0  <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      vld_p0 <= complete;
      if (clear_err) seq_err <= 1'b0;
      if (seq_evt)   seq_err <= 1'b1;
      case (state)
        IDLE: begin
          if (idle_start && !SINGLE) begin
            state   <= ACCUM;
            exp_idx <= 16'd1;
          end
        end
        ACCUM: begin
          if (acc_ok) begin
            if (complete) state <= IDLE;
            else          exp_idx <= exp_idx + 16'd1;
          end else if (sum_valid) begin
            if (acc_restart) exp_idx <= 16'd1;
            else             state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      best       <= sum;
      best_idx   <= '0;
      second     <= COST_SENTINEL;
      coords_lat <= in_coords;
    end else if (acc_ok) begin
      best     <= acc_best;
      best_idx <= acc_idx;
      second   <= acc_second;
    end
    // Stage p0: completed result heading into the queue.
    if (complete) begin
      if (idle_start) res_p0 <= make_result(sum, COST_SENTINEL, 8'd0, in_coords);
      else            res_p0 <= make_result(acc_best, acc_second, acc_idx, coords_lat);
    end
  end

  // Stage p1: queue write; a full queue only accepts when it is popped this cycle.
  assign drop = vld_p0 && fifo_full && !(out_valid && out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else begin
      if (clear_err) overflow <= 1'b0;
      if (drop)      overflow <= 1'b1;
    end
  end

  result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (vld_p0),
    .push_data  (res_p0),
    .ready      (out_ready),
    .head       (head),
    .head_valid (out_valid),
    .full       (fifo_full)
  );

  assign out_disp   = head.disp;
  assign out_cost   = head.cost;
  assign out_coords = head.coords;
  assign out_conf   = head.conf;

endmodule
